stream_mux: RTL and testbench
=============================

// Module: stream_mux
// PURPOSE
// - Parametrised successor of the registered 2:1 data mux: N-channel, WIDTH-bit stream mux, valid/ready handshake.
// - Two selection modes: fixed select (channel chosen by Sel) or round-robin arbitration over valid channels.
// - One registered output stage; sits between N producer streams and a single consumer.
// - Full throughput: one transfer per cycle.
// PARAMETERS
// - WIDTH  32  data width per channel
// - N      4   number of input channels, N >= 2
// - SEL_W  $clog2(N)  select/channel-index width (derived, do not override)
// PORTS
// - Clk      input   1        single clock, all state on posedge
// - Reset    input   1        asynchronous, active-low reset (0 = in reset)
// - Mode     input   1        0 = fixed select via Sel; 1 = round-robin
// - Sel      input   SEL_W    channel index used when Mode=0
// - In_data  input   N*WIDTH  channel i occupies bits [i*WIDTH +: WIDTH]
// - In_val   input   N        per-channel valid
// - In_rdy   output  N        per-channel ready; at most one bit set
// - Out      output  WIDTH    registered output data
// - Out_sel  output  SEL_W    index of the channel that supplied Out
// - Out_val  output  1        Out/Out_sel valid
// - Out_rdy  input   1        consumer ready
// BEHAVIOUR
// - Reset asserted (Reset=0, async): Out=0, Out_sel=0, Out_val=0, RR pointer=N-1 (channel 0 wins first); In_rdy=0.
// - Load enable: ld = !Out_val || Out_rdy. Combinational; In_rdy depends on Out_rdy in the same cycle.
// - Grant g (combinational, each cycle):
//   - Mode=0: g=Sel if Sel<N and In_val[Sel]; otherwise no grant. Sel>=N never grants.
//   - Mode=1: first i with In_val[i]=1, searching ptr+1, ptr+2, ... with wrap modulo N; no grant if In_val==0.
// - In_rdy[g] = ld when a grant exists; all other In_rdy bits = 0.
// - Input transfer: In_val[g] && In_rdy[g].
//   - Next posedge: Out <= In_data[g], Out_sel <= g, Out_val <= 1.
//   - Mode=1 only: ptr <= g. Mode=0 never changes ptr.
// - Output transfer: Out_val && Out_rdy. If there is no simultaneous input transfer, Out_val <= 0 next posedge. Out and Out_sel hold their last value.
// - Simultaneous output and input transfer: the new item replaces the old item with no bubble (back-to-back throughput).
// - Stall (Out_val=1, Out_rdy=0): Out, Out_sel and Out_val stay stable; In_rdy=0; no input is consumed.
// - Latency: accepted input appears on Out exactly 1 cycle later.
// - Producers hold In_val and In_data stable until their In_rdy is seen. A grant that is not consumed (stall) may move to another channel in Mode=1; this is legal because no transfer occurred.
// - Mode or Sel changes take effect in the next arbitration cycle. An item already in the output register is unaffected. ptr is retained across mode switches.
// - Reset asserted mid-stream: the output item is discarded and Out_val drops immediately (async). Arbitration restarts from channel 0 after release.
// TESTING
// - Reset: Out_val=1 holding 0xA5A5A5A5, drive Reset=0 between clocks -> Out_val=0, Out=0 before next posedge. After release, Mode=1 with all valid -> first Out_sel=0.
// - Fixed: Mode=0, Sel=2, In_val=4'b0100, ch2=0xDEADBEEF, Out_rdy=1 -> In_rdy=4'b0100; next cycle Out=0xDEADBEEF, Out_sel=2, Out_val=1.
// - Round-robin dense: Mode=1, In_val=4'b1111 held, Out_rdy=1 -> Out_sel 0,1,2,3,0 on consecutive cycles, Out_val continuously 1.
// - Round-robin sparse: Mode=1, In_val=4'b1001 held, Out_rdy=1 -> Out_sel 0,3,0,3; In_rdy never set for channels 1 or 2.
// - Backpressure: Out_val=1, Out_rdy=0 for 3 cycles -> Out/Out_sel unchanged, In_rdy=0. Raise Out_rdy -> next item on following cycle; scoreboard shows no loss or duplication.
// - Out-of-range select: N=3, Mode=0, Sel=3, In_val=3'b111 -> In_rdy=0. Pending item drains on Out_rdy=1, then Out_val=0.

Source files
------------

// File: rtl/stream_mux.sv
// stream_mux: N-channel, WIDTH-bit valid/ready stream multiplexer with one
// registered output stage. Channel selection is either a fixed index (Mode=0)
// or round-robin over the valid channels (Mode=1). Sustains one transfer per
// cycle because the output register reloads in the same cycle it drains.
module stream_mux #(
  parameter int WIDTH = 32,
  parameter int N     = 4,
  parameter int SEL_W = $clog2(N)
) (
  input  logic               Clk,
  input  logic               Reset,
  input  logic               Mode,
  input  logic [SEL_W-1:0]   Sel,
  input  logic [N*WIDTH-1:0] In_data,
  input  logic [N-1:0]       In_val,
  output logic [N-1:0]       In_rdy,
  output logic [WIDTH-1:0]   Out,
  output logic [SEL_W-1:0]   Out_sel,
  output logic               Out_val,
  input  logic               Out_rdy
);

  logic [WIDTH-1:0] out_q,     out_d;
  logic [SEL_W-1:0] out_sel_q, out_sel_d;
  logic             out_val_q, out_val_d;
  logic [SEL_W-1:0] ptr_q,     ptr_d;

  logic             ld_s;
  logic             grant_vld_s;
  logic [SEL_W-1:0] grant_s;
  logic [WIDTH-1:0] data_s;
  logic             xfer_in_s;

  // The output register can take a new item when it is empty or being drained
  // this cycle. Held low during reset so no producer sees a ready.
  assign ld_s = Reset & (~out_val_q | Out_rdy);

  // Arbitration: fixed index match, or first valid channel after the pointer.
  always_comb begin
    logic             hit;
    logic [SEL_W-1:0] idx;
    grant_vld_s = 1'b0;
    grant_s     = '0;
    hit         = 1'b0;
    idx         = '0;
    if (Mode == 1'b0) begin
      // An out-of-range Sel matches no loop index, so it never grants.
      for (int i = 0; i < N; i++) begin
        hit         = (Sel == SEL_W'(i)) && In_val[i];
        grant_s     = hit ? SEL_W'(i) : grant_s;
        grant_vld_s = grant_vld_s | hit;
      end
    end else begin
      // Search ptr+1, ptr+2, ... wrapping modulo N; the first valid wins.
      for (int k = 1; k <= N; k++) begin
        idx         = SEL_W'((int'(ptr_q) + k) % N);
        hit         = In_val[idx] && !grant_vld_s;
        grant_s     = hit ? idx : grant_s;
        grant_vld_s = grant_vld_s | hit;
      end
    end
  end

  // Data of the granted channel.
  always_comb begin
    data_s = '0;
    for (int i = 0; i < N; i++) begin
      data_s = (grant_s == SEL_W'(i)) ? In_data[i*WIDTH +: WIDTH] : data_s;
    end
  end

  // One-hot ready toward the granted producer only.
  always_comb begin
    In_rdy = '0;
    for (int i = 0; i < N; i++) begin
      In_rdy[i] = grant_vld_s && ld_s && (grant_s == SEL_W'(i));
    end
  end

  assign xfer_in_s = grant_vld_s & ld_s;

  // Next state of the output stage and the round-robin pointer.
  always_comb begin
    out_d     = out_q;
    out_sel_d = out_sel_q;
    out_val_d = out_val_q;
    ptr_d     = ptr_q;
    if (xfer_in_s) begin
      out_d     = data_s;
      out_sel_d = grant_s;
      out_val_d = 1'b1;
      if (Mode == 1'b1) begin
        ptr_d = grant_s;
      end else begin
        ptr_d = ptr_q;
      end
    end else if (out_val_q && Out_rdy) begin
      // Drained with nothing to replace it: data and index keep last value.
      out_val_d = 1'b0;
    end else begin
      out_val_d = out_val_q;
    end
  end

  // State registers; the pointer resets to N-1 so channel 0 wins first.
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      out_q     <= '0;
      out_sel_q <= '0;
      out_val_q <= 1'b0;
      ptr_q     <= SEL_W'(N - 1);
    end else begin
      out_q     <= out_d;
      out_sel_q <= out_sel_d;
      out_val_q <= out_val_d;
      ptr_q     <= ptr_d;
    end
  end

  assign Out     = out_q;
  assign Out_sel = out_sel_q;
  assign Out_val = out_val_q;

endmodule

// File: tb/tb_stream_mux.sv
// Testbench for stream_mux: directed vectors with a scoreboard queue filled by
// the stimulus and drained by an independent output monitor.
module tb_stream_mux;

  logic         clk;
  logic         rst_n;
  // N=4 instance
  logic         mode;
  logic [1:0]   sel;
  logic [127:0] in_data;
  logic [3:0]   in_val;
  logic [3:0]   in_rdy;
  logic [31:0]  out;
  logic [1:0]   out_sel;
  logic         out_val;
  logic         out_rdy;
  // N=3 instance
  logic         mode3;
  logic [1:0]   sel3;
  logic [95:0]  in_data3;
  logic [2:0]   in_val3;
  logic [2:0]   in_rdy3;
  logic [31:0]  out3;
  logic [1:0]   out_sel3;
  logic         out_val3;
  logic         out_rdy3;

  int n_cmp = 0;
  int n_err = 0;
  logic [33:0] sb[$];

  stream_mux #(.WIDTH(32), .N(4)) dut4 (
    .Clk(clk), .Reset(rst_n), .Mode(mode), .Sel(sel),
    .In_data(in_data), .In_val(in_val), .In_rdy(in_rdy),
    .Out(out), .Out_sel(out_sel), .Out_val(out_val), .Out_rdy(out_rdy)
  );

  stream_mux #(.WIDTH(32), .N(3)) dut3 (
    .Clk(clk), .Reset(rst_n), .Mode(mode3), .Sel(sel3),
    .In_data(in_data3), .In_val(in_val3), .In_rdy(in_rdy3),
    .Out(out3), .Out_sel(out_sel3), .Out_val(out_val3), .Out_rdy(out_rdy3)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Apply one cycle of inputs, check ready, and queue the expected item.
  task automatic drive(input logic m, input logic [1:0] s, input logic [3:0] v,
                       input logic rdy, input logic [3:0] exp_rdy, input string name);
    @(negedge clk);
    mode = m; sel = s; in_val = v; out_rdy = rdy;
    #1;
    check(name, {28'd0, in_rdy}, {28'd0, exp_rdy});
    for (int i = 0; i < 4; i++) begin
      if (exp_rdy[i]) sb.push_back({i[1:0], in_data[i*32 +: 32]});
    end
  endtask

  // Monitor: a transfer happens at the next posedge whenever Out_val && Out_rdy.
  initial begin
    logic [33:0] e;
    forever begin
      @(negedge clk);
      #2;
      if (rst_n && out_val && out_rdy) begin
        if (sb.size() == 0) begin
          n_cmp++;
          n_err++;
          $display("FAIL unexpected_output: got %h/%0d expected none", out, out_sel);
        end else begin
          e = sb.pop_front();
          check("sb_data", out, e[31:0]);
          check("sb_sel", {30'd0, out_sel}, {30'd0, e[33:32]});
        end
      end
    end
  end

  initial begin
    rst_n = 1'b0; mode = 1'b1; sel = 2'd0; in_val = 4'b1111; out_rdy = 1'b1;
    in_data = {32'h4444_0003, 32'hDEADBEEF, 32'h2222_0001, 32'h1111_0000};
    mode3 = 1'b0; sel3 = 2'd0; in_val3 = 3'b000; out_rdy3 = 1'b0;
    in_data3 = {32'h3333_0002, 32'h3333_0001, 32'h3333_0000};

    // Reset state
    #12;
    check("rst_out_val", {31'd0, out_val}, 32'd0);
    check("rst_out", out, 32'd0);
    check("rst_out_sel", {30'd0, out_sel}, 32'd0);
    check("rst_in_rdy", {28'd0, in_rdy}, 32'd0);
    @(negedge clk);
    in_val = 4'b0000;
    rst_n = 1'b1;

    // Fixed select
    drive(1'b0, 2'd2, 4'b0100, 1'b1, 4'b0100, "fixed_rdy");
    drive(1'b0, 2'd2, 4'b0000, 1'b1, 4'b0000, "fixed_idle");
    check("fixed_out", out, 32'hDEADBEEF);
    check("fixed_sel", {30'd0, out_sel}, 32'd2);
    check("fixed_val", {31'd0, out_val}, 32'd1);
    drive(1'b0, 2'd2, 4'b0000, 1'b1, 4'b0000, "fixed_idle2");
    check("fixed_drained", {31'd0, out_val}, 32'd0);

    // Round-robin dense: pointer is still N-1, so 0,1,2,3,0,1,2,3
    for (int c = 0; c < 8; c++) begin
      logic [3:0] onehot;
      onehot = 4'b0001 << (c % 4);
      drive(1'b1, 2'd0, 4'b1111, 1'b1, onehot, "rr_dense_rdy");
      if (c > 0) check("rr_dense_val", {31'd0, out_val}, 32'd1);
    end

    // Round-robin sparse: pointer at 3, so 0,3,0,3
    for (int c = 0; c < 4; c++) begin
      drive(1'b1, 2'd0, 4'b1001, 1'b1, (c % 2 == 0) ? 4'b0001 : 4'b1000, "rr_sparse_rdy");
    end

    // Backpressure: ch3 item held for 3 cycles
    for (int c = 0; c < 3; c++) begin
      drive(1'b1, 2'd0, 4'b1001, 1'b0, 4'b0000, "bp_rdy");
      check("bp_out", out, 32'h4444_0003);
      check("bp_sel", {30'd0, out_sel}, 32'd3);
      check("bp_val", {31'd0, out_val}, 32'd1);
    end
    drive(1'b1, 2'd0, 4'b1001, 1'b1, 4'b0001, "bp_release");
    drive(1'b1, 2'd0, 4'b0000, 1'b1, 4'b0000, "bp_idle");
    check("bp_next_out", out, 32'h1111_0000);
    drive(1'b1, 2'd0, 4'b0000, 1'b1, 4'b0000, "bp_idle2");
    check("bp_drained", {31'd0, out_val}, 32'd0);

    // Mid-stream reset
    in_data[31:0] = 32'hA5A5A5A5;
    drive(1'b0, 2'd0, 4'b0001, 1'b0, 4'b0001, "mrst_load");
    @(negedge clk);
    in_val = 4'b0000;
    #1;
    check("mrst_pre_val", {31'd0, out_val}, 32'd1);
    check("mrst_pre_out", out, 32'hA5A5A5A5);
    rst_n = 1'b0;
    #1;
    check("mrst_val", {31'd0, out_val}, 32'd0);
    check("mrst_out", out, 32'd0);
    check("mrst_in_rdy", {28'd0, in_rdy}, 32'd0);
    sb.delete();
    @(negedge clk);
    rst_n = 1'b1;
    drive(1'b1, 2'd0, 4'b1111, 1'b1, 4'b0001, "mrst_rr_first");
    drive(1'b1, 2'd0, 4'b0000, 1'b1, 4'b0000, "mrst_idle");
    check("mrst_first_sel", {30'd0, out_sel}, 32'd0);
    drive(1'b1, 2'd0, 4'b0000, 1'b1, 4'b0000, "mrst_idle2");

    // N=3: load ch1, then select out of range
    @(negedge clk);
    mode3 = 1'b0; sel3 = 2'd1; in_val3 = 3'b111; out_rdy3 = 1'b0;
    #1;
    check("n3_load_rdy", {29'd0, in_rdy3}, 32'd2);
    @(negedge clk);
    #1;
    check("n3_out", out3, 32'h3333_0001);
    check("n3_sel", {30'd0, out_sel3}, 32'd1);
    check("n3_val", {31'd0, out_val3}, 32'd1);
    sel3 = 2'd3; out_rdy3 = 1'b1;
    #1;
    check("n3_oor_rdy", {29'd0, in_rdy3}, 32'd0);
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      #1;
      check("n3_drained_val", {31'd0, out_val3}, 32'd0);
      check("n3_drained_rdy", {29'd0, in_rdy3}, 32'd0);
      check("n3_hold_out", out3, 32'h3333_0001);
    end

    @(negedge clk);
    #3;
    check("sb_empty", sb.size(), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
